// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point accumulator slice:
// FSM state encoding and the signed saturation limits for an N-bit word.
package fixed_point_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } acc_state_t;

   // FP_MAX = 2^(n-1)-1 and FP_MIN = -2^(n-1); callers size-cast to n bits
   function automatic logic [63:0] fp_max(input int unsigned n);
      return (64'd1 << (n - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] fp_min(input int unsigned n);
      return 64'd1 << (n - 1);
   endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit two's-complement add/subtract with carry, signed overflow and
// true-sign (negative) flags; purely combinational.
module carry_lookahead_adder #(
   parameter int unsigned N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         is_subtract,
   output logic [N-1:0] result,
   output logic         carry_out,
   output logic         overflow_flag,
   output logic         negative
);

   logic [N-1:0] b_eff;
   logic [N-1:0] gen;
   logic [N-1:0] prop;
   logic [N:0]   carry;

   assign b_eff = b ^ {N{is_subtract}};
   assign gen   = a & b_eff;
   assign prop  = a ^ b_eff;

   always_comb begin
      carry    = '0;
      carry[0] = is_subtract;
      for (int unsigned i = 0; i < N; i++) begin
         carry[i+1] = gen[i] | (prop[i] & carry[i]);
      end
   end

   assign result        = prop ^ carry[N-1:0];
   assign carry_out     = carry[N];
   assign overflow_flag = carry[N] ^ carry[N-1];
   // sign of the exact result: the stored sign bit is inverted when it overflowed
   assign negative      = result[N-1] ^ overflow_flag;

endmodule

// File: rtl/fixed_point_accumulator.sv
// Signed fixed-point accumulator: sums/subtracts len samples, returns one result
// per run with a sticky overflow flag. Define ACC_SATURATE_EN to clamp on overflow.
module fixed_point_accumulator
   import fixed_point_pkg::*;
#(
   parameter int unsigned N       = 16,
   parameter int unsigned COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COUNT_W-1:0] len,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_data,
   input  logic               in_sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       out_data,
   output logic               out_saturated
);

   acc_state_t         state, state_d;
   logic [N-1:0]       acc, acc_d;
   logic [COUNT_W-1:0] remaining, remaining_d;
   logic               sticky, sticky_d;

   logic [N-1:0]       add_result;
   logic               add_carry_unused;
   logic               add_ovf;
   logic               add_neg;
   logic [N-1:0]       next_sum;

`ifdef ACC_SATURATE_EN
   localparam logic [N-1:0] SAT_MAX = N'(fp_max(N));
   localparam logic [N-1:0] SAT_MIN = N'(fp_min(N));
`else
   logic sign_unused;
   assign sign_unused = add_neg;
`endif

   carry_lookahead_adder #(
      .N (N)
   ) u_adder (
      .a             (acc),
      .b             (in_data),
      .is_subtract   (in_sub),
      .result        (add_result),
      .carry_out     (add_carry_unused),
      .overflow_flag (add_ovf),
      .negative      (add_neg)
   );

   always_comb begin
      next_sum = add_result;
`ifdef ACC_SATURATE_EN
      if (add_ovf) begin
         next_sum = add_neg ? SAT_MIN : SAT_MAX;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         sticky    <= 1'b0;
      end else begin
         state     <= state_d;
         acc       <= acc_d;
         remaining <= remaining_d;
         sticky    <= sticky_d;
      end
   end

   always_comb begin
      state_d       = state;
      acc_d         = acc;
      remaining_d   = remaining;
      sticky_d      = sticky;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      out_data      = acc;
      out_saturated = sticky;

      unique case (state)
         IDLE: begin
            if (start) begin
               remaining_d = len;
               acc_d       = '0;
               sticky_d    = 1'b0;
               state_d     = (len != '0) ? ACCUM : DONE;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d       = next_sum;
               sticky_d    = sticky | add_ovf;
               remaining_d = remaining - COUNT_W'(1);
               if (remaining == COUNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
